// File: rtl/rv32m_divider_pkg.sv
// Shared types and constants for the RV32M iterative divider.
// DIV/DIVU/REM/REMU encodings match the multiplier-extension decoder.
package rv32m_divider_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned DIV_OP_WIDTH = 2;
  localparam int unsigned CNT_W        = 5;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [DIV_OP_WIDTH-1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PREP    = 3'd1,
    ST_CALC    = 3'd2,
    ST_DONE    = 3'd3,
    ST_WAITLOW = 3'd4
  } div_state_e;

  // Two's-complement negate; INT_MIN maps onto itself.
  function automatic logic [XLEN-1:0] neg_xlen(input logic [XLEN-1:0] x);
    return XLEN'(~x + XLEN'(1));
  endfunction

  function automatic logic op_is_signed(input div_op_e op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

endpackage

// File: rtl/rv32m_divider_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface rv32m_divider_if;
  import rv32m_divider_pkg::*;

  logic                    div_valid;
  logic [DIV_OP_WIDTH-1:0] DIVop;
  logic [XLEN-1:0]         dividend;
  logic [XLEN-1:0]         divisor;
  logic                    div_ready;
  logic [XLEN-1:0]         div_result;

  modport master (
    output div_valid, DIVop, dividend, divisor,
    input  div_ready, div_result
  );

  modport slave (
    input  div_valid, DIVop, dividend, divisor,
    output div_ready, div_result
  );

endinterface

// File: rtl/rv32m_divider_div_restore_step.sv
// One combinational radix-2 restoring division iteration.
module div_restore_step
  import rv32m_divider_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN:0] w_trial;

  // The partial remainder stays below the divisor, so bit XLEN is a valid sign.
  assign w_trial = {i_rem, i_q[XLEN-1]} - {1'b0, i_divisor};
  assign o_rem   = w_trial[XLEN] ? {i_rem[XLEN-2:0], i_q[XLEN-1]} : w_trial[XLEN-1:0];
  assign o_q     = {i_q[XLEN-2:0], ~w_trial[XLEN]};

endmodule

// File: rtl/rv32m_divider.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, 32 restoring iterations per operation.
// Optional feature macro: RV32M_DIV_EARLY_OUT_EN (skip iterations when |dividend| < |divisor|).
module rv32m_divider
  import rv32m_divider_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  rv32m_divider_if.slave bus
);

  div_state_e       r_state;
  div_op_e          r_op;
  logic [XLEN-1:0]  r_a;
  logic [XLEN-1:0]  r_b;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_q;
  logic [XLEN-1:0]  r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_ready;

  logic             w_signed;
  logic             w_is_rem;
  logic             w_div_zero;
  logic             w_ovf;
  logic             w_early;
  logic [XLEN-1:0]  w_abs_a;
  logic [XLEN-1:0]  w_abs_b;
  logic [XLEN-1:0]  w_step_rem;
  logic [XLEN-1:0]  w_step_q;
  logic [XLEN-1:0]  w_q_fix;
  logic [XLEN-1:0]  w_r_fix;

  assign w_signed   = op_is_signed(r_op);
  assign w_is_rem   = (r_op == DIV_OP_REM) || (r_op == DIV_OP_REMU);
  assign w_abs_a    = (w_signed && r_a[XLEN-1]) ? neg_xlen(r_a) : r_a;
  assign w_abs_b    = (w_signed && r_b[XLEN-1]) ? neg_xlen(r_b) : r_b;
  assign w_div_zero = (r_b == '0);
  assign w_ovf      = w_signed && (r_a == INT_MIN) && (r_b == '1);

`ifdef RV32M_DIV_EARLY_OUT_EN
  assign w_early = !w_div_zero && (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  // r_b holds |divisor| once PREP has run.
  div_restore_step u_step (
    .i_rem     (r_rem),
    .i_q       (r_q),
    .i_divisor (r_b),
    .o_rem     (w_step_rem),
    .o_q       (w_step_q)
  );

  assign w_q_fix = r_neg_q ? neg_xlen(r_q)   : r_q;
  assign w_r_fix = r_neg_r ? neg_xlen(r_rem) : r_rem;

  assign bus.div_ready  = r_ready;
  assign bus.div_result = r_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= DIV_OP_DIV;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.div_valid) begin
            r_op    <= div_op_e'(bus.DIVop);
            r_a     <= bus.dividend;
            r_b     <= bus.divisor;
            r_state <= ST_PREP;
          end
        end
        ST_PREP: begin
          r_b   <= w_abs_b;
          r_cnt <= CNT_W'(XLEN - 1);
          if (w_div_zero) begin
            r_q     <= '1;
            r_rem   <= r_a;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_ovf) begin
            r_q     <= INT_MIN;
            r_rem   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_early) begin
            r_q     <= '0;
            r_rem   <= w_abs_a;
            r_neg_q <= 1'b0;
            r_neg_r <= w_signed && r_a[XLEN-1];
            r_state <= ST_DONE;
          end else begin
            r_q     <= w_abs_a;
            r_rem   <= '0;
            r_neg_q <= w_signed && (r_a[XLEN-1] ^ r_b[XLEN-1]);
            r_neg_r <= w_signed && r_a[XLEN-1];
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_rem <= w_step_rem;
          r_q   <= w_step_q;
          if (r_cnt == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_result <= w_is_rem ? w_r_fix : w_q_fix;
          r_ready  <= 1'b1;
          r_state  <= ST_WAITLOW;
        end
        ST_WAITLOW: begin
          // Wait for the initiator to drop valid so one request yields one result.
          if (!bus.div_valid) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_divider.sv
// Scoreboard bench for rv32m_divider: reference model built on native integer division.
module tb_rv32m_divider;
  import rv32m_divider_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   n_ready = 0;
  int   n_req = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rv32m_divider_if bus ();

  rv32m_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      2'b00: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      2'b01: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      2'b10: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    logic sgn;
    logic [31:0] ma;
    logic [31:0] mb;
    sgn = (op == 2'b00) || (op == 2'b10);
    ma  = (sgn && a[31]) ? 32'(-a) : a;
    mb  = (sgn && b[31]) ? 32'(-b) : b;
    if (b == 32'd0) return 2;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef RV32M_DIV_EARLY_OUT_EN
    if (ma < mb) return 2;
`else
    if (ma < mb) return 34;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return 32'(-32'($urandom_range(1, 20)));
      default: return 32'($urandom);
    endcase
  endfunction

  // Monitor: every div_ready pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (bus.div_ready === 1'b1) begin
      n_ready++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ready cyc=%0d result=%h required=no pulse", cyc, bus.div_result);
      end else begin
        e = sb_q.pop_front();
        if (bus.div_result !== e.res) begin
          failures++;
          $display("FAIL result cyc=%0d got=%h required=%h", cyc, bus.div_result, e.res);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL latency got_cyc=%0d required_cyc=%0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold);
    exp_t e;
    int   n0;
    int   budget;
    tick();
    bus.div_valid = 1'b1;
    bus.DIVop     = op;
    bus.dividend  = a;
    bus.divisor   = b;
    e.res = ref_div(op, a, b);
    e.cyc = cyc + 1 + ref_lat(op, a, b);
    sb_q.push_back(e);
    n_req++;
    n0 = n_ready;
    tick();
    bus.DIVop    = 2'($urandom);
    bus.dividend = 32'($urandom);
    bus.divisor  = 32'($urandom);
    budget = 0;
    while (n_ready == n0 && budget < 100) begin
      tick();
      budget++;
    end
    checks++;
    if (n_ready == n0) begin
      failures++;
      $display("FAIL timeout op=%0d a=%h b=%h waited=%0d cycles", op, a, b, budget);
      sb_q.delete();
      n_req--;
    end
    repeat (hold) tick();
    if (hold > 0) begin
      checks++;
      if (bus.div_result !== e.res) begin
        failures++;
        $display("FAIL result_hold got=%h required=%h", bus.div_result, e.res);
      end
    end
    bus.div_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (bus.div_ready !== 1'b0 || bus.div_result !== 32'd0) begin
      failures++;
      $display("FAIL %s ready=%b result=%h required ready=0 result=0", tag, bus.div_ready,
               bus.div_result);
    end
  endtask

  task automatic reset_mid_calc();
    int c0;
    tick();
    bus.div_valid = 1'b1;
    bus.DIVop     = 2'b00;
    bus.dividend  = 32'd123456;
    bus.divisor   = 32'd7;
    c0 = cyc + 1;
    while (cyc < c0 + 12) tick();
    reset = 1'b1;
    bus.div_valid = 1'b0;
    tick();
    check_idle_outputs("reset_mid_calc");
    reset = 1'b0;
    repeat (40) tick();
    check_idle_outputs("after_abandon");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.div_valid = 1'b0;
    bus.DIVop     = 2'b00;
    bus.dividend  = 32'd0;
    bus.divisor   = 32'd0;
    repeat (3) tick();
    check_idle_outputs("reset_state");
    reset = 1'b0;

    run_req(2'b00, 32'd100, 32'd7, 0);
    run_req(2'b10, 32'hFFFF_FF9C, 32'd7, 0);
    run_req(2'b01, 32'hFFFF_FFFF, 32'd2, 0);
    run_req(2'b01, 32'd5, 32'd0, 0);
    run_req(2'b11, 32'd5, 32'd0, 0);
    run_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_req(2'b00, 32'd3, 32'd100, 0);
    run_req(2'b10, 32'hFFFF_FFFD, 32'd100, 0);
    run_req(2'b00, 32'hFFFF_FFF9, 32'd2, 10);
    run_req(2'b01, 32'd9, 32'd3, 0);
    reset_mid_calc();
    run_req(2'b00, 32'd100, 32'd7, 0);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      run_req(2'($urandom), pick(), pick(), int'($urandom_range(0, 2)));
    end

    repeat (5) tick();
    checks++;
    if (n_ready != n_req || sb_q.size() != 0) begin
      failures++;
      $display("FAIL pulse_count pulses=%0d required=%0d pending=%0d", n_ready, n_req,
               sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
